// File: rtl/eth_ingress_arbiter.sv
// Packet-granular round-robin arbiter sharing one L2 header parser between NUM_PORTS
// ingress byte streams, with a mid-frame stall watchdog that aborts hung packets.
module eth_ingress_arbiter #(
    parameter int NUM_PORTS     = 4,
    parameter int DATA_W        = 8,
    parameter int STALL_TIMEOUT = 64,
    localparam int PORT_W       = $clog2(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        in_valid,
    input  logic [NUM_PORTS*DATA_W-1:0] in_data,
    input  logic [NUM_PORTS-1:0]        in_last,
    output logic [NUM_PORTS-1:0]        in_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_last,
    output logic                        out_abort,
    output logic [PORT_W-1:0]           out_port,
    input  logic                        out_ready,
    output logic                        busy,
    output logic [15:0]                 abort_count
);

    localparam int STALL_W = (STALL_TIMEOUT > 2) ? $clog2(STALL_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FWD   = 2'd1,
        S_ABORT = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              state_r, state_n;
    logic [PORT_W-1:0]   grant_r, grant_n;
    logic [PORT_W-1:0]   rr_ptr_r, rr_ptr_n;
    logic [STALL_W-1:0]  stall_r, stall_n;
    logic [15:0]         abort_count_r, abort_count_n;

    logic [PORT_W-1:0]   pick_port_s;
    logic [PORT_W-1:0]   cand_s;
    logic                pick_any_s;
    logic                sel_valid_s;
    logic                sel_last_s;
    logic [DATA_W-1:0]   sel_data_s;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    // Round-robin pick: the scan runs from farthest to nearest so the nearest valid port after rr_ptr wins.
    always_comb begin
        pick_port_s = '0;
        cand_s      = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            cand_s      = PORT_W'((int'(rr_ptr_r) + k) % NUM_PORTS);
            pick_port_s = in_valid[cand_s] ? cand_s : pick_port_s;
        end
    end

    assign pick_any_s = |in_valid;

    // Mux of the granted port's beat.
    always_comb begin
        sel_valid_s = in_valid[grant_r];
        sel_last_s  = in_last[grant_r];
        sel_data_s  = in_data[int'(grant_r)*DATA_W +: DATA_W];
    end

    // Next-state and output logic; FWD is a zero-latency pass-through of the granted port.
    always_comb begin
        state_n       = state_r;
        grant_n       = grant_r;
        rr_ptr_n      = rr_ptr_r;
        stall_n       = stall_r;
        abort_count_n = abort_count_r;
        in_ready      = '0;
        out_valid     = 1'b0;
        out_data      = '0;
        out_last      = 1'b0;
        out_abort     = 1'b0;
        out_port      = '0;
        case (state_r)
            S_IDLE: begin
                if (pick_any_s) begin
                    grant_n = pick_port_s;
                    stall_n = '0;
                    state_n = S_FWD;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_FWD: begin
                out_valid         = sel_valid_s;
                out_data          = sel_data_s;
                out_last          = sel_last_s;
                out_port          = grant_r;
                in_ready[grant_r] = out_ready;
                if (sel_valid_s) begin
                    stall_n = '0;
                    if (out_ready && sel_last_s) begin
                        rr_ptr_n = grant_r;
                        state_n  = S_IDLE;
                    end else begin
                        state_n = S_FWD;
                    end
                end else if (stall_r == STALL_W'(STALL_TIMEOUT - 1)) begin
                    state_n = S_ABORT;
                end else begin
                    stall_n = stall_r + STALL_W'(1);
                end
            end
            S_ABORT: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_abort = 1'b1;
                out_port  = grant_r;
                if (out_ready) begin
                    abort_count_n = sat_inc16(abort_count_r);
                    state_n       = S_DRAIN;
                end else begin
                    state_n = S_ABORT;
                end
            end
            S_DRAIN: begin
                in_ready[grant_r] = 1'b1;
                if (sel_valid_s && sel_last_s) begin
                    rr_ptr_n = grant_r;
                    state_n  = S_IDLE;
                end else begin
                    state_n = S_DRAIN;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            grant_r       <= '0;
            rr_ptr_r      <= PORT_W'(NUM_PORTS - 1);
            stall_r       <= '0;
            abort_count_r <= 16'd0;
        end else begin
            state_r       <= state_n;
            grant_r       <= grant_n;
            rr_ptr_r      <= rr_ptr_n;
            stall_r       <= stall_n;
            abort_count_r <= abort_count_n;
        end
    end

    assign busy        = (state_r != S_IDLE);
    assign abort_count = abort_count_r;

endmodule

// File: tb/tb_eth_ingress_arbiter.sv
// Self-checking bench for eth_ingress_arbiter: table-driven packets with a scoreboard
// of expected output beats, plus hand-written round-robin, reset and backpressure sequences.
`timescale 1ns/1ps
module tb_eth_ingress_arbiter;
    localparam int NP = 4;
    localparam int DW = 8;
    localparam int TO = 64;
    localparam int PW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP-1:0]     in_valid;
    logic [NP*DW-1:0]  in_data;
    logic [NP-1:0]     in_last;
    logic [NP-1:0]     in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic              out_abort;
    logic [PW-1:0]     out_port;
    logic              out_ready;
    logic              busy;
    logic [15:0]       abort_count;

    typedef struct { logic [7:0] data; bit last; bit gap; } src_t;
    typedef struct { int port; logic [7:0] data; bit last; bit abrt; } beat_t;
    typedef struct { int port; int len; int gap_len; int tail; bit exp_abort; } vec_t;

    src_t  src_q [NP][$];
    beat_t exp_q [$];
    vec_t  vecs [6];
    bit    shown [NP];
    logic [NP-1:0] acc_v;

    int total = 0;
    int bad = 0;
    int exp_aborts = 0;
    int n;
    bit stable_ok;

    always #5 clk = ~clk;

    eth_ingress_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .STALL_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_abort(out_abort),
        .out_port(out_port), .out_ready(out_ready), .busy(busy), .abort_count(abort_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Compare one output handshake against the head of the scoreboard.
    task automatic check_beat();
        beat_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL beat: unexpected port=%0d data=%02h last=%0b abort=%0b",
                     out_port, out_data, out_last, out_abort);
        end else begin
            e = exp_q.pop_front();
            if (int'(out_port) != e.port || out_data !== e.data ||
                out_last !== e.last || out_abort !== e.abrt) begin
                bad++;
                $display("FAIL beat: got port=%0d data=%02h last=%0b abort=%0b want port=%0d data=%02h last=%0b abort=%0b",
                         out_port, out_data, out_last, out_abort, e.port, e.data, e.last, e.abrt);
            end
        end
    endtask

    function automatic bit src_empty();
        bit r = 1'b1;
        for (int i = 0; i < NP; i++) begin
            if (src_q[i].size() != 0) r = 1'b0;
        end
        return r;
    endfunction

    // Queue a packet: len bytes, gap_len idle cycles, then tail bytes; expectation built alongside.
    task automatic push_pkt(input int port, input int len, input int gap_len, input int tail, input bit ab);
        src_t  s;
        beat_t b;
        for (int k = 0; k < len; k++) begin
            s.data = 8'($urandom_range(0, 255));
            s.last = (gap_len == 0 && tail == 0 && k == len - 1);
            s.gap  = 1'b0;
            src_q[port].push_back(s);
            b = '{port, s.data, s.last, 1'b0};
            exp_q.push_back(b);
        end
        for (int k = 0; k < gap_len; k++) begin
            s = '{8'h00, 1'b0, 1'b1};
            src_q[port].push_back(s);
        end
        for (int k = 0; k < tail; k++) begin
            s.data = 8'($urandom_range(0, 255));
            s.last = (k == tail - 1);
            s.gap  = 1'b0;
            src_q[port].push_back(s);
            if (!ab) begin
                b = '{port, s.data, s.last, 1'b0};
                exp_q.push_back(b);
            end
        end
        if (ab) begin
            b = '{port, 8'h00, 1'b1, 1'b1};
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_idle(input string name, input int maxc);
        int c = 0;
        while (!(exp_q.size() == 0 && src_empty() && !busy) && c < maxc) begin
            tick();
            c++;
        end
        total++;
        if (c >= maxc) begin
            bad++;
            $display("FAIL %s: timeout after %0d cycles, pending=%0d busy=%0b", name, c, exp_q.size(), busy);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_aborts = 0;
    endtask

    // Source driver and output monitor: sample at negedge, update sources just after posedge.
    initial begin
        in_valid = '0;
        in_data  = '0;
        in_last  = '0;
        for (int i = 0; i < NP; i++) shown[i] = 1'b0;
        forever begin
            @(negedge clk);
            acc_v = in_valid & in_ready;
            if (out_valid === 1'b1 && out_ready === 1'b1) check_beat();
            @(posedge clk);
            #2;
            for (int i = 0; i < NP; i++) begin
                if (shown[i] && src_q[i].size() > 0 && (src_q[i][0].gap || acc_v[i]))
                    void'(src_q[i].pop_front());
                if (src_q[i].size() > 0 && !src_q[i][0].gap) begin
                    in_valid[i]          = 1'b1;
                    in_data[i*DW +: DW]  = src_q[i][0].data;
                    in_last[i]           = src_q[i][0].last;
                end else begin
                    in_valid[i] = 1'b0;
                    in_last[i]  = 1'b0;
                end
                shown[i] = (src_q[i].size() > 0);
            end
        end
    end

    initial begin
        vecs[0] = '{0, 20, 0,   0, 1'b0};   // 20-byte frame
        vecs[1] = '{3, 1,  0,   0, 1'b0};   // single-beat packet
        vecs[2] = '{2, 4,  63,  2, 1'b0};   // one idle cycle short of the timeout
        vecs[3] = '{0, 5,  64,  3, 1'b1};   // exactly the timeout
        vecs[4] = '{1, 2,  100, 1, 1'b1};
        vecs[5] = '{3, 3,  1,   1, 1'b0};

        rst_n     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst out_port", 32'(out_port), 32'd0);
        chk("rst abort_count", 32'(abort_count), 32'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            push_pkt(vecs[v].port, vecs[v].len, vecs[v].gap_len, vecs[v].tail, vecs[v].exp_abort);
            if (vecs[v].exp_abort) exp_aborts++;
            wait_idle("vector idle", 600);
            chk("vector abort_count", 32'(abort_count), 32'(exp_aborts));
        end

        // Reset in the middle of a forwarded packet drops it without an abort beat.
        push_pkt(0, 10, 0, 0, 1'b0);
        n = 0;
        while (exp_q.size() > 6 && n < 100) begin
            tick();
            n++;
        end
        chk("midpkt reached", 32'(exp_q.size() <= 6), 32'd1);
        rst_n = 1'b0;
        src_q[0].delete();
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        exp_aborts = 0;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst out_last", 32'(out_last), 32'd0);
        chk("midrst out_abort", 32'(out_abort), 32'd0);
        chk("midrst in_ready", 32'(in_ready), 32'd0);
        chk("midrst out_port", 32'(out_port), 32'd0);
        chk("midrst abort_count", 32'(abort_count), 32'd0);
        repeat (5) tick();

        // From reset rr_ptr points at the last port, so ports 0,1,2 are served in order.
        apply_reset();
        push_pkt(0, 3, 0, 0, 1'b0);
        push_pkt(1, 3, 0, 0, 1'b0);
        push_pkt(2, 3, 0, 0, 1'b0);
        wait_idle("rr three ports", 200);

        // Port 1 back-to-back with port 2 waiting: expected order 1,2,1.
        apply_reset();
        push_pkt(1, 3, 0, 0, 1'b0);
        push_pkt(2, 2, 0, 0, 1'b0);
        push_pkt(1, 4, 0, 0, 1'b0);
        wait_idle("rr back-to-back", 200);

        // Long backpressure mid-packet: no abort, beat held stable.
        push_pkt(2, 8, 0, 0, 1'b0);
        n = 0;
        while (exp_q.size() > 5 && n < 100) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        stable_ok = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_abort !== 1'b0 || busy !== 1'b1 ||
                exp_q.size() == 0 || out_data !== exp_q[0].data || out_port !== 2'd2)
                stable_ok = 1'b0;
        end
        chk("backpressure hold", 32'(stable_ok), 32'd1);
        tick();
        out_ready = 1'b1;
        wait_idle("backpressure resume", 200);
        chk("backpressure abort_count", 32'(abort_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_ingress_arbiter.md
Name: eth_ingress_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single L2 Ethernet header parser between NUM_PORTS ingress byte streams.
- Once a port is granted, it owns the parser until its last byte. The grant does not change mid-packet.
- A stall watchdog aborts any packet whose source stops sending mid-frame, so the parser never hangs.
- Sits between the MAC RX ports and the parser. out_port travels alongside each beat so the parser can tag its eth_metadata_t with the source port.

Parameters:
- NUM_PORTS, 4, number of ingress requesters (2..8).
- DATA_W, 8, beat width in bits (one byte_t per beat).
- STALL_TIMEOUT, 64, consecutive idle cycles mid-packet before abort (>=2).
- PORT_W, $clog2(NUM_PORTS), derived width of port index; not overridable.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  NUM_PORTS  per-port beat valid
- in_data  in  NUM_PORTS*DATA_W  per-port beat data; port i at [i*DATA_W +: DATA_W]
- in_last  in  NUM_PORTS  per-port last beat of packet
- in_ready  out  NUM_PORTS  per-port beat accepted when valid&ready
- out_valid  out  1  beat valid toward parser
- out_data  out  DATA_W  beat data
- out_last  out  1  last beat of packet
- out_abort  out  1  qualifies out_last: packet truncated, parser must discard metadata
- out_port  out  PORT_W  source port of current beat
- out_ready  in  1  parser ready
- busy  out  1  high in any state except IDLE
- abort_count  out  16  saturating count of aborted packets

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE, grant=0, rr_ptr=NUM_PORTS-1, stall_cnt=0, abort_count=0.
  - All outputs are 0: in_ready, out_valid, out_last, out_abort, out_port, busy.
  - Reset mid-packet drops the packet silently; no abort beat is emitted.
- States: IDLE, FWD, ABORT, DRAIN.
- IDLE:
  - If any in_valid is high, grant the first valid port searching rr_ptr+1, rr_ptr+2, ... modulo NUM_PORTS.
  - Register the grant and go to FWD on the next cycle.
  - No in_ready is asserted in IDLE. This gives a one-cycle arbitration bubble per packet.
- FWD (zero-latency combinational pass-through of the granted port):
  - out_valid = in_valid[grant]; out_data and out_last come from port grant; out_port = grant; out_abort = 0.
  - in_ready[grant] = out_ready; in_ready of every other port = 0.
  - On an accepted beat with in_last: rr_ptr <= grant, go to IDLE.
- Stall watchdog (FWD only):
  - stall_cnt increments each cycle in_valid[grant]=0 and resets to 0 on any cycle in_valid[grant]=1.
  - Backpressure from out_ready=0 with valid high does not count as a stall.
  - When stall_cnt reaches STALL_TIMEOUT-1 and in_valid[grant] is still 0, go to ABORT.
- ABORT:
  - out_valid=1, out_last=1, out_abort=1, out_data=0, out_port=grant; in_ready all 0.
  - Hold until out_ready. On the handshake, abort_count increments (saturating at 16'hFFFF) and the state goes to DRAIN.
- DRAIN:
  - in_ready[grant]=1 and out_valid=0; the granted port's beats are discarded.
  - On an accepted beat with in_last: rr_ptr <= grant, go to IDLE.
  - A port that never sends in_last holds DRAIN indefinitely. This is accepted behaviour.
- rr_ptr updates only at packet end, so every requester is served within NUM_PORTS packets.
- Single-beat packet (in_last on the first beat) is legal.
- stall_cnt clears on entry to FWD.
- busy = (state != IDLE).
- in_valid on ungranted ports has no effect until the next IDLE arbitration.

Test Plan:
- Single port 0, 20-byte frame, out_ready=1 → 20 beats on the output with out_port=0, out_last on beat 20, then one idle cycle before busy drops.
- Ports 0,1,2 each hold a 3-byte packet from reset → grant order 0,1,2. Each packet is contiguous with no interleaving. Port 3 is never granted.
- Port 1 sends 2 packets back-to-back while port 2 requests → order 1,2,1.
- Port 0 sends 5 bytes then drops valid; STALL_TIMEOUT=64 → abort beat (out_last=1, out_abort=1) appears 64 cycles after the last valid and abort_count=1. Later bytes up to in_last are consumed with out_valid=0, then arbitration resumes.
- out_ready held low 200 cycles mid-packet with in_valid high → no abort, data held stable, transfer resumes intact.
- rst_n asserted mid-packet during FWD → next cycle state is IDLE, all outputs 0, abort_count=0.
